// File: rtl/rename_recovery_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : rename_recovery_ctrl_if
// Brief     : Signal bundle between the recovery controller and its
//             neighbours (commit, rename, issue/ROB, fetch).
//             The master side drives the inputs. The slave side is the controller.
// Revision  : 1.0  initial release
// ============================================================================
interface rename_recovery_ctrl_if #(
   parameter int NUM_ARCH_REG = 16,
   parameter int WORD_SIZE_P  = 16
);
   localparam int BASE_W = $clog2(NUM_ARCH_REG);

   logic                   commit_v_i;
   logic                   mispredict_i;
   logic [WORD_SIZE_P-1:0] resolved_pc_i;
   logic                   rob_empty_i;
   logic                   issue_empty_i;
   logic                   fetch_ready_i;
   logic                   rename_stall_o;
   logic                   flush_o;
   logic                   restore_v_o;
   logic [BASE_W-1:0]      restore_base_o;
   logic                   restore_fl_o;
   logic                   redirect_v_o;
   logic [WORD_SIZE_P-1:0] redirect_pc_o;
   logic                   busy_o;
   logic [15:0]            recover_cnt_o;

   modport master (
      output commit_v_i, mispredict_i, resolved_pc_i,
             rob_empty_i, issue_empty_i, fetch_ready_i,
      input  rename_stall_o, flush_o, restore_v_o, restore_base_o,
             restore_fl_o, redirect_v_o, redirect_pc_o, busy_o, recover_cnt_o
   );

   modport slave (
      input  commit_v_i, mispredict_i, resolved_pc_i,
             rob_empty_i, issue_empty_i, fetch_ready_i,
      output rename_stall_o, flush_o, restore_v_o, restore_base_o,
             restore_fl_o, redirect_v_o, redirect_pc_o, busy_o, recover_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/rename_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module    : rename_recovery_ctrl
// Brief     : Branch-mispredict recovery sequencer for the rename stage.
//             The sequence is stall, flush, wait for drain, copy the
//             non-speculative LUT back in beats, then a fetch redirect.
// Revision  : 1.0  initial release
// ============================================================================
module rename_recovery_ctrl #(
   parameter int NUM_ARCH_REG   = 16,
   parameter int NUM_PHYS_REG   = 32,
   parameter int COPY_PER_CYCLE = 4,
   parameter int WORD_SIZE_P    = 16
) (
   input  wire logic             clk_i,
   input  wire logic             reset_i,
   rename_recovery_ctrl_if.slave bus
);

   localparam int BASE_W = $clog2(NUM_ARCH_REG);
   // The base counter is one bit wider so that stepping past the last beat does not wrap.
   localparam int CNT_W  = BASE_W + 1;
   localparam logic [CNT_W-1:0] BASE_STEP = CNT_W'(COPY_PER_CYCLE);
   localparam logic [CNT_W-1:0] LAST_BASE = CNT_W'(NUM_ARCH_REG - COPY_PER_CYCLE);
   localparam bit CFG_OK = (NUM_PHYS_REG > NUM_ARCH_REG)
                        && ((NUM_ARCH_REG & (NUM_ARCH_REG - 1)) == 0)
                        && ((COPY_PER_CYCLE & (COPY_PER_CYCLE - 1)) == 0)
                        && ((NUM_ARCH_REG % COPY_PER_CYCLE) == 0);

   // Reject parameter sets the beat sequencing cannot handle.
   if (!CFG_OK) begin : g_cfg_error
      $error("rename_recovery_ctrl: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FLUSH    = 3'd1,
      S_DRAIN    = 3'd2,
      S_RESTORE  = 3'd3,
      S_REDIRECT = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       base_q, base_d;
   logic [WORD_SIZE_P-1:0] pc_q, pc_d;
   logic [15:0]            cnt_q, cnt_d;
   logic                   w_trigger;

   // Gate the trigger with reset so that every output reads zero while reset is held.
   assign w_trigger = bus.commit_v_i & bus.mispredict_i & reset_i;

   // State and datapath registers: async assert, sync release.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and outputs. A trigger overrides every state and restarts at FLUSH.
   always_comb begin
      state_d            = state_q;
      base_d             = base_q;
      pc_d               = pc_q;
      cnt_d              = cnt_q;
      bus.flush_o        = 1'b0;
      bus.restore_v_o    = 1'b0;
      bus.restore_base_o = '0;
      bus.restore_fl_o   = 1'b0;
      bus.redirect_v_o   = 1'b0;
      bus.redirect_pc_o  = '0;

      case (state_q)
         S_FLUSH: begin
            bus.flush_o = 1'b1;
            state_d     = S_DRAIN;
         end
         S_DRAIN: begin
            base_d = '0;
            if (bus.rob_empty_i && bus.issue_empty_i) begin
               state_d = S_RESTORE;
            end
         end
         S_RESTORE: begin
            bus.restore_v_o    = 1'b1;
            bus.restore_base_o = base_q[BASE_W-1:0];
            // The freelist and its pointers are restored together with the first beat only.
            bus.restore_fl_o   = (base_q == '0);
            base_d             = base_q + BASE_STEP;
            if (base_q == LAST_BASE) begin
               state_d = S_REDIRECT;
            end
         end
         S_REDIRECT: begin
            bus.redirect_v_o  = 1'b1;
            bus.redirect_pc_o = pc_q;
            if (bus.fetch_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
         end
      endcase

      if (w_trigger) begin
         state_d = S_FLUSH;
         base_d  = '0;
         pc_d    = bus.resolved_pc_i;
         if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   assign bus.busy_o         = (state_q != S_IDLE);
   assign bus.rename_stall_o = (state_q != S_IDLE) | w_trigger;
   assign bus.recover_cnt_o  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rename_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module    : tb_rename_recovery_ctrl
// Brief     : Scoreboard bench for rename_recovery_ctrl. Directed scenarios
//             push the expected flush, beat and redirect events, each tagged
//             with its cycle, and a negedge monitor pops and compares them.
// Revision  : 1.0  initial release
// ============================================================================
module tb_rename_recovery_ctrl;

   typedef struct {
      int cyc;
      int val;
      bit fl;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;
   bit   mon_en;

   exp_t q_flush[$];
   exp_t q_beat[$];
   exp_t q_redir[$];

   rename_recovery_ctrl_if #(.NUM_ARCH_REG(16), .WORD_SIZE_P(16)) bus ();

   rename_recovery_ctrl #(
      .NUM_ARCH_REG  (16),
      .NUM_PHYS_REG  (32),
      .COPY_PER_CYCLE(4),
      .WORD_SIZE_P   (16)
   ) dut (
      .clk_i  (clk),
      .reset_i(rst_n),
      .bus    (bus)
   );

   // Free-running clock and cycle counter.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
      end
   endtask

   // Monitor: every visible event must match the head of its queue.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (bus.flush_o) begin
            if (q_flush.size() == 0) chk("unexpected_flush", 1, 0);
            else begin
               e = q_flush.pop_front();
               chk("flush_cycle", cyc, e.cyc);
            end
         end
         if (bus.restore_v_o) begin
            if (q_beat.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
               e = q_beat.pop_front();
               chk("beat_cycle", cyc, e.cyc);
               chk("beat_base", int'(bus.restore_base_o), e.val);
               chk("beat_fl", int'(bus.restore_fl_o), int'(e.fl));
            end
         end
         if (bus.redirect_v_o) begin
            if (q_redir.size() == 0) chk("unexpected_redirect", 1, 0);
            else begin
               e = q_redir.pop_front();
               chk("redirect_cycle", cyc, e.cyc);
               chk("redirect_pc", int'(bus.redirect_pc_o), e.val);
            end
         end
      end
   end

   task automatic run_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_flush(input int c);
      q_flush.push_back('{cyc: c, val: 0, fl: 1'b0});
   endtask

   task automatic push_beats(input int c0, input int n);
      for (int k = 0; k < n; k++) begin
         q_beat.push_back('{cyc: c0 + k, val: 4 * k, fl: (k == 0)});
      end
   endtask

   task automatic push_redir(input int c0, input int n, input int pc);
      for (int k = 0; k < n; k++) begin
         q_redir.push_back('{cyc: c0 + k, val: pc, fl: 1'b0});
      end
   endtask

   task automatic fire(input logic [15:0] pc);
      bus.commit_v_i    = 1'b1;
      bus.mispredict_i  = 1'b1;
      bus.resolved_pc_i = pc;
   endtask

   task automatic unfire();
      bus.commit_v_i   = 1'b0;
      bus.mispredict_i = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stall"}, int'(bus.rename_stall_o), 0);
      chk({tag, "_flush"}, int'(bus.flush_o), 0);
      chk({tag, "_restore_v"}, int'(bus.restore_v_o), 0);
      chk({tag, "_restore_base"}, int'(bus.restore_base_o), 0);
      chk({tag, "_restore_fl"}, int'(bus.restore_fl_o), 0);
      chk({tag, "_redirect_v"}, int'(bus.redirect_v_o), 0);
      chk({tag, "_redirect_pc"}, int'(bus.redirect_pc_o), 0);
      chk({tag, "_busy"}, int'(bus.busy_o), 0);
      chk({tag, "_cnt"}, int'(bus.recover_cnt_o), 0);
   endtask

   // Directed stimulus.
   initial begin
      int t;
      cyc    = 0;
      checks = 0;
      errors = 0;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      bus.commit_v_i    = 1'b0;
      bus.mispredict_i  = 1'b0;
      bus.resolved_pc_i = '0;
      bus.rob_empty_i   = 1'b1;
      bus.issue_empty_i = 1'b1;
      bus.fetch_ready_i = 1'b1;
      #3;
      chk_all_zero("reset");
      run_to(3);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      run_to(5);

      // Basic recovery with minimum latency.
      t = cyc;
      fire(16'h0040);
      push_flush(t + 1);
      push_beats(t + 3, 4);
      push_redir(t + 7, 1, 16'h0040);
      #1;
      chk("trig_stall_comb", int'(bus.rename_stall_o), 1);
      chk("trig_busy", int'(bus.busy_o), 0);
      run_to(t + 1);
      unfire();
      run_to(t + 7);
      chk("t1_stall_in_redirect", int'(bus.rename_stall_o), 1);
      run_to(t + 8);
      chk("t1_busy_done", int'(bus.busy_o), 0);
      chk("t1_stall_done", int'(bus.rename_stall_o), 0);
      chk("t1_cnt", int'(bus.recover_cnt_o), 1);

      // ROB not yet empty, so the controller waits in DRAIN.
      run_to(t + 10);
      t = cyc;
      bus.rob_empty_i = 1'b0;
      fire(16'h1234);
      push_flush(t + 1);
      run_to(t + 1);
      unfire();
      run_to(t + 7);
      chk("drain_stall", int'(bus.rename_stall_o), 1);
      chk("drain_busy", int'(bus.busy_o), 1);
      chk("drain_no_restore", int'(bus.restore_v_o), 0);
      run_to(t + 12);
      bus.rob_empty_i = 1'b1;
      push_beats(t + 13, 4);
      push_redir(t + 17, 1, 16'h1234);
      run_to(t + 18);
      chk("t2_busy_done", int'(bus.busy_o), 0);
      chk("t2_cnt", int'(bus.recover_cnt_o), 2);

      // A second trigger arrives during the base=8 beat.
      run_to(t + 20);
      t = cyc;
      fire(16'h0100);
      push_flush(t + 1);
      push_beats(t + 3, 3);
      run_to(t + 1);
      unfire();
      run_to(t + 5);
      fire(16'h0080);
      push_flush(t + 6);
      push_beats(t + 8, 4);
      push_redir(t + 12, 1, 16'h0080);
      #1;
      chk("nest_stall", int'(bus.rename_stall_o), 1);
      chk("nest_base_now", int'(bus.restore_base_o), 8);
      run_to(t + 6);
      unfire();
      run_to(t + 13);
      chk("t3_busy_done", int'(bus.busy_o), 0);
      chk("t3_cnt", int'(bus.recover_cnt_o), 4);

      // Fetch holds off the redirect for five cycles.
      run_to(t + 15);
      t = cyc;
      bus.fetch_ready_i = 1'b0;
      fire(16'hBEEF);
      push_flush(t + 1);
      push_beats(t + 3, 4);
      push_redir(t + 7, 6, 16'hBEEF);
      run_to(t + 1);
      unfire();
      run_to(t + 12);
      bus.fetch_ready_i = 1'b1;
      run_to(t + 13);
      chk("t4_busy_done", int'(bus.busy_o), 0);
      chk("t4_stall_done", int'(bus.rename_stall_o), 0);
      chk("t4_cnt", int'(bus.recover_cnt_o), 5);

      // A commit without a mispredict is never a trigger.
      run_to(t + 15);
      bus.commit_v_i   = 1'b1;
      bus.mispredict_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         bus.resolved_pc_i = 16'($urandom);
         #1;
         chk("nontrig_stall", int'(bus.rename_stall_o), 0);
         run_to(cyc + 1);
      end
      bus.commit_v_i = 1'b0;
      chk("nontrig_cnt", int'(bus.recover_cnt_o), 5);
      chk("nontrig_busy", int'(bus.busy_o), 0);

      // Async reset asserted between edges during RESTORE.
      run_to(cyc + 2);
      t = cyc;
      fire(16'h2222);
      push_flush(t + 1);
      push_beats(t + 3, 1);
      run_to(t + 1);
      unfire();
      run_to(t + 4);
      chk("pre_reset_restore_v", int'(bus.restore_v_o), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      run_to(t + 6);
      rst_n = 1'b1;
      run_to(t + 16);
      chk("post_reset_busy", int'(bus.busy_o), 0);
      chk("post_reset_cnt", int'(bus.recover_cnt_o), 0);
      chk("post_reset_stall", int'(bus.rename_stall_o), 0);

      // Every expected event must have been consumed.
      run_to(cyc + 3);
      chk("left_flush", q_flush.size(), 0);
      chk("left_beat", q_beat.size(), 0);
      chk("left_redir", q_redir.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
